// File: rtl/vedic_pkg.sv
// Shared helpers for the pipelined Vedic multiplier: width legality, latency, valid-vector type.
package vedic_pkg;

  localparam int MAX_LATENCY = 16;

  typedef logic [MAX_LATENCY-1:0] vld_vec_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One register level for the 2x2 base plus one per halving step.
  function automatic int latency_of(input int width);
    return clog2(width);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 2) && ((width & (width - 1)) == 0) && (clog2(width) <= MAX_LATENCY);
  endfunction

endpackage

// File: rtl/vedic_nxn_stage.sv
// One Urdhva-Tiryagbhyam level: four half-width products merged by a registered adder.
// Latency clog2(N) cycles; each level's register loads only when its en bit is set.
module vedic_nxn_stage
  import vedic_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [clog2(N)-1:0] en,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  output logic [2*N-1:0]      p
);

  if (N == 2) begin : g_base
    logic [3:0] p_d;
    logic       c1;

    always_comb begin
      p_d[0] = a[0] & b[0];
      p_d[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
      c1     = (a[1] & b[0]) & (a[0] & b[1]);
      p_d[2] = (a[1] & b[1]) ^ c1;
      p_d[3] = (a[1] & b[1]) & c1;
    end

    always_ff @(posedge clk) begin
      if (rst)        p <= '0;
      else if (en[0]) p <= p_d;
    end
  end else begin : g_rec
    localparam int LG = clog2(N);
    localparam int H  = N / 2;

    logic [N-1:0]   pp_ll, pp_hl, pp_lh, pp_hh;
    logic [N:0]     mid;
    logic [2*N-1:0] sum;

    vedic_nxn_stage #(.N(H)) u_ll (
      .clk(clk), .rst(rst), .en(en[LG-2:0]), .a(a[H-1:0]), .b(b[H-1:0]), .p(pp_ll)
    );
    vedic_nxn_stage #(.N(H)) u_hl (
      .clk(clk), .rst(rst), .en(en[LG-2:0]), .a(a[N-1:H]), .b(b[H-1:0]), .p(pp_hl)
    );
    vedic_nxn_stage #(.N(H)) u_lh (
      .clk(clk), .rst(rst), .en(en[LG-2:0]), .a(a[H-1:0]), .b(b[N-1:H]), .p(pp_lh)
    );
    vedic_nxn_stage #(.N(H)) u_hh (
      .clk(clk), .rst(rst), .en(en[LG-2:0]), .a(a[N-1:H]), .b(b[N-1:H]), .p(pp_hh)
    );

    // Cross terms summed at N+1 bits so the carry survives the shift.
    always_comb begin
      mid = {1'b0, pp_hl} + {1'b0, pp_lh};
      sum = {{N{1'b0}}, pp_ll} + ({{(N-1){1'b0}}, mid} << H) + {pp_hh, {N{1'b0}}};
    end

    always_ff @(posedge clk) begin
      if (rst)            p <= '0;
      else if (en[LG-1])  p <= sum;
    end
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Pipelined unsigned Vedic multiplier, WIDTH x WIDTH -> 2*WIDTH, latency log2(WIDTH).
// A held output (out_valid && !out_ready) freezes every stage and drops in_ready.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int       LATENCY = latency_of(WIDTH);
  localparam vld_vec_t LIVE    = vld_vec_t'((64'd1 << LATENCY) - 64'd1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be a power of two between 2 and 65536");
  end

  logic               stall;
  vld_vec_t           vld_q;
  vld_vec_t           vld_adv;
  logic [LATENCY-1:0] load;

  assign out_valid = vld_q[LATENCY-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  // A level's data register only loads when a valid token enters it, so
  // bubbles leave the data untouched and result keeps the last product.
  always_comb begin
    vld_adv = ((vld_q << 1) | vld_vec_t'(in_valid)) & LIVE;
    load    = vld_adv[LATENCY-1:0] & {LATENCY{!stall}};
  end

  always_ff @(posedge clk) begin
    if (rst)         vld_q <= '0;
    else if (!stall) vld_q <= vld_adv;
  end

  vedic_nxn_stage #(.N(WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .en (load),
    .a  (a),
    .b  (b),
    .p  (result)
  );

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe at WIDTH 32, 8 and 2: queue-based product/latency model plus directed literals.
module tb_vedic_mult_pipe;

  localparam int NDUT = 3;
  localparam int D32  = 0;
  localparam int D8   = 1;
  localparam int D2   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [NDUT];
  logic        out_ready [NDUT];
  logic [31:0] a         [NDUT];
  logic [31:0] b         [NDUT];
  wire         in_ready  [NDUT];
  wire         out_valid [NDUT];
  wire  [63:0] result    [NDUT];

  bit          rnd_rdy [NDUT];
  int          n_in    [NDUT];
  int          n_out   [NDUT];
  int          pending [NDUT];
  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned tcyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W   = (g == 0) ? 32 : ((g == 1) ? 8 : 2);
    localparam int LAT = $clog2(W);

    logic [2*W-1:0] res_w;

    vedic_mult_pipe #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a[g][W-1:0]),
      .b        (b[g][W-1:0]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .result   (res_w)
    );
    assign result[g] = 64'(res_w);

    // Model: every accepted pair must come out once, in order, as a*b, exactly
    // LAT cycles later plus one cycle per stall cycle seen in between.
    longint unsigned exp_q[$];
    int unsigned     acc_q[$];
    int unsigned     stl_q[$];
    int unsigned     cyc        = 0;
    int unsigned     stalls     = 0;
    logic            prev_stall = 1'b0;
    logic [63:0]     prev_res   = '0;

    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        exp_q.delete();
        acc_q.delete();
        stl_q.delete();
        prev_stall = 1'b0;
        prev_res   = '0;
      end else begin
        chk($sformatf("w%0d_in_ready", W), 64'(in_ready[g]),
            64'(!(out_valid[g] && !out_ready[g])));
        if (prev_stall) begin
          chk($sformatf("w%0d_hold_valid", W), 64'(out_valid[g]), 64'd1);
          chk($sformatf("w%0d_hold_result", W), result[g], prev_res);
        end else if (!out_valid[g]) begin
          chk($sformatf("w%0d_idle_result", W), result[g], prev_res);
        end
        if (out_valid[g] && exp_q.size() == 0) begin
          chk($sformatf("w%0d_stale_valid", W), 64'(out_valid[g]), 64'd0);
        end else if (out_valid[g] && out_ready[g]) begin
          chk($sformatf("w%0d_product", W), result[g], exp_q[0]);
          chk($sformatf("w%0d_latency", W), 64'(cyc - acc_q[0]),
              64'(LAT + stalls - stl_q[0]));
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(stl_q.pop_front());
          n_out[g]++;
        end
        if (exp_q.size() != 0 && (cyc - acc_q[0]) > (LAT + stalls - stl_q[0])) begin
          chk($sformatf("w%0d_lost_product", W), 64'(cyc - acc_q[0]),
              64'(LAT + stalls - stl_q[0]));
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(stl_q.pop_front());
        end
        if (out_valid[g] && !out_ready[g]) stalls++;
        if (in_valid[g] && in_ready[g]) begin
          exp_q.push_back(64'(a[g][W-1:0]) * 64'(b[g][W-1:0]));
          acc_q.push_back(cyc);
          stl_q.push_back(stalls);
          n_in[g]++;
        end
        prev_stall = out_valid[g] && !out_ready[g];
        prev_res   = result[g];
      end
      pending[g] = exp_q.size();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++)
      if (rnd_rdy[g]) out_ready[g] = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < NDUT; g++) in_valid[g] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int g, input logic [31:0] aa, input logic [31:0] bb);
    bit acc;
    int n;
    in_valid[g] = 1'b1;
    a[g]        = aa;
    b[g]        = bb;
    n           = 0;
    do begin
      @(negedge clk);
      acc = in_ready[g];
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'(n), 64'd0);
  endtask

  task automatic wait_out(input int g, input int lat, input logic [63:0] exp, input string nm);
    int  j;
    bit  seen;
    in_valid[g] = 1'b0;
    j    = 0;
    seen = 1'b0;
    while (!seen && j < 40) begin
      @(negedge clk);
      j++;
      seen = out_valid[g];
    end
    chk({nm, "_lat"}, 64'(j), 64'(lat));
    chk({nm, "_res"}, result[g], exp);
    tick();
  endtask

  initial begin
    int          j;
    int unsigned t0;
    rst = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      a[g]         = '0;
      b[g]         = '0;
      rnd_rdy[g]   = 1'b0;
      n_in[g]      = 0;
      n_out[g]     = 0;
      pending[g]   = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk("reset_out_valid", 64'(out_valid[g]), 64'd0);
      chk("reset_result", result[g], 64'd0);
      chk("reset_in_ready", 64'(in_ready[g]), 64'd1);
    end
    tick();

    send(D32, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(D32, 5, 64'hFFFF_FFFE_0000_0001, "max32");
    send(D8, 32'd255, 32'd255);
    wait_out(D8, 3, 64'h0000_0000_0000_FE01, "max8");
    send(D2, 32'd3, 32'd3);
    wait_out(D2, 1, 64'd9, "w2_3x3");
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        send(D2, 32'(i), 32'(k));
        wait_out(D2, 1, 64'(i * k), "w2_pair");
      end

    // Output held for 7 cycles while the source keeps offering 3*5.
    out_ready[D32] = 1'b0;
    send(D32, 32'h1234_5678, 32'h9ABC_DEF0);
    in_valid[D32] = 1'b1;
    a[D32]        = 32'd3;
    b[D32]        = 32'd5;
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (!out_valid[D32] && j < 40);
    chk("stall_first_lat", 64'(j), 64'd5);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", 64'(out_valid[D32]), 64'd1);
      chk("stall_result", result[D32], 64'h0B00_EA4E_242D_2080);
      chk("stall_in_ready", 64'(in_ready[D32]), 64'd0);
    end
    tick();
    out_ready[D32] = 1'b1;
    idle(12);

    t0 = tcyc;
    for (int i = 0; i < 1000; i++) send(D32, $urandom, $urandom);
    chk("stream_cycles", 64'(tcyc - t0), 64'd1000);
    idle(10);

    for (int i = 0; i < 3; i++) send(D32, $urandom, $urandom);
    in_valid[D32] = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid[D32]), 64'd0);
    chk("midrst_result", result[D32], 64'd0);
    chk("midrst_in_ready", 64'(in_ready[D32]), 64'd1);
    tick();
    idle(12);

    rnd_rdy[D8] = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid[D8] = 1'b0;
        tick();
      end
      send(D8, 32'(i % 256), 32'((i * 131 + i / 256) % 256));
    end
    rnd_rdy[D8]   = 1'b0;
    out_ready[D8] = 1'b1;
    idle(20);

    for (int g = 0; g < NDUT; g++) chk("drained", 64'(pending[g]), 64'd0);
    chk("w8_count_in_out", 64'(n_out[D8]), 64'(n_in[D8]));
    chk("w8_count_in", 64'(n_in[D8]), 64'd8193);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
